// File: rtl/mux8_rr_arbiter.sv
// Eight-lane round-robin arbiter feeding one registered 64-bit 8:1 select with valid/ready.
// Optional burst lock on a granted lane is enabled with `define ARB_LOCK_EN.
module mux8_rr_arbiter #(
  parameter int unsigned WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_valid,
  input  logic [7:0][WIDTH-1:0] in_data,
  input  logic [7:0]            in_lock,
  output logic [7:0]            in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [2:0]            out_sel,
  input  logic                  out_ready
);

  localparam int unsigned LANES = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_data;
  logic [SEL_W-1:0]   r_sel;
  logic [SEL_W-1:0]   r_ptr;

  logic               w_load_ok;
  logic               w_found;
  logic [SEL_W-1:0]   w_pick;
  logic [SEL_W-1:0]   w_idx;
  logic               w_grant;

`ifdef ARB_LOCK_EN
  logic               r_lock_act;
  logic [SEL_W-1:0]   r_lock_lane;
`else
  logic               w_unused_lock;
  assign w_unused_lock = ^in_lock;
`endif

  // Scan from ptr upward; iterating high-to-low leaves the nearest valid lane in w_pick.
  always_comb begin
    w_load_ok = (r_state == S_EMPTY) || out_ready;
    w_found   = 1'b0;
    w_pick    = r_ptr;
    w_idx     = r_ptr;
    for (int i = LANES - 1; i >= 0; i--) begin
      w_idx = r_ptr + SEL_W'(i);
      if (in_valid[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
`ifdef ARB_LOCK_EN
    if (r_lock_act) begin
      w_found = in_valid[r_lock_lane];
      w_pick  = r_lock_lane;
    end
`endif
    w_grant  = w_found && w_load_ok && !reset;
    in_ready = w_grant ? (LANES'(1) << w_pick) : '0;
  end

  // Output register, round-robin pointer and optional lock state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_EMPTY;
      r_data      <= '0;
      r_sel       <= '0;
      r_ptr       <= '0;
`ifdef ARB_LOCK_EN
      r_lock_act  <= 1'b0;
      r_lock_lane <= '0;
`endif
    end else if (w_grant) begin
      r_state <= S_FULL;
      r_data  <= in_data[w_pick];
      r_sel   <= w_pick;
`ifdef ARB_LOCK_EN
      if (r_lock_act) begin
        if (!in_lock[w_pick]) begin
          r_lock_act <= 1'b0;
          r_ptr      <= w_pick + SEL_W'(1);
        end
      end else if (in_lock[w_pick]) begin
        r_lock_act  <= 1'b1;
        r_lock_lane <= w_pick;
      end else begin
        r_ptr <= w_pick + SEL_W'(1);
      end
`else
      r_ptr   <= w_pick + SEL_W'(1);
`endif
    end else if (w_load_ok) begin
      r_state <= S_EMPTY;
    end
  end

  assign out_valid = (r_state == S_FULL);
  assign out_data  = r_data;
  assign out_sel   = r_sel;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter: directed scenarios plus random traffic
// compared against a lane-scanning reference model.
module tb_mux8_rr_arbiter;

  localparam int unsigned WIDTH = 64;

  logic                  clk;
  logic                  reset;
  logic [7:0]            in_valid;
  logic [7:0][WIDTH-1:0] in_data;
  logic [7:0]            in_lock;
  logic [7:0]            in_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [2:0]            out_sel;
  logic                  out_ready;

  int n_checks;
  int n_pass;
  int n_fail;

  // Reference model state
  int           m_ptr;
  bit           m_full;
  logic [63:0]  m_data;
  int           m_sel;
  bit           m_lock_act;
  int           m_lock_lane;

  longint unsigned lane_vals [8] = '{64357, 26000, 24556, 12328, 63, 31, 132346, 7};

  mux8_rr_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_lock   (in_lock),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Lane the model expects to be granted this cycle, or -1.
  function automatic int exp_grant();
    if (m_full && !out_ready) return -1;
    if (m_lock_act) return in_valid[m_lock_lane] ? m_lock_lane : -1;
    for (int i = 0; i < 8; i++) begin
      if (in_valid[(m_ptr + i) % 8]) return (m_ptr + i) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr       = 0;
    m_full      = 1'b0;
    m_data      = '0;
    m_sel       = 0;
    m_lock_act  = 1'b0;
    m_lock_lane = 0;
  endtask

  // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic cycle(input string tag);
    int g;
    #2;
    g = exp_grant();
    chk({tag, "_in_ready"}, 64'(in_ready), (g < 0) ? 64'd0 : (64'd1 << g));
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(m_full));
    chk({tag, "_out_data"}, out_data, m_data);
    chk({tag, "_out_sel"}, 64'(out_sel), 64'(m_sel));
    @(posedge clk);
    if (g >= 0) begin
      m_data = in_data[g];
      m_sel  = g;
      m_full = 1'b1;
`ifdef ARB_LOCK_EN
      if (m_lock_act) begin
        if (!in_lock[g]) begin
          m_lock_act = 1'b0;
          m_ptr      = (g + 1) % 8;
        end
      end else if (in_lock[g]) begin
        m_lock_act  = 1'b1;
        m_lock_lane = g;
      end else begin
        m_ptr = (g + 1) % 8;
      end
`else
      m_ptr = (g + 1) % 8;
`endif
    end else if (!m_full || out_ready) begin
      m_full = 1'b0;
    end
    #1;
  endtask

  initial begin
    int n4;
    int e;
    n_checks  = 0;
    n_pass    = 0;
    n_fail    = 0;
    model_reset();
    reset     = 1'b1;
    in_valid  = 8'hFF;
    in_lock   = 8'h00;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) in_data[i] = 64'(lane_vals[i]);

    // Reset state
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_sel", 64'(out_sel), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    in_valid = 8'h00;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Full contention: grants rotate 0..7 then 0
    in_valid = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      cycle("contend");
      chk("contend_sel", 64'(out_sel), 64'(i % 8));
      chk("contend_data", out_data, 64'(lane_vals[i % 8]));
    end

    // Reset asserted mid-stall discards the held beat
    out_ready = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_data", out_data, 64'd0);
    chk("midrst_out_sel", 64'(out_sel), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    in_valid = 8'h00;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Backpressure with lanes 2 and 5
    out_ready = 1'b1;
    in_valid  = 8'b0010_0100;
    cycle("bp_load");
    chk("bp_first", out_data, 64'd24556);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle("bp_stall");
      chk("bp_hold", out_data, 64'd24556);
    end
    out_ready = 1'b1;
    cycle("bp_rel");
    chk("bp_next5", out_data, 64'd31);
    cycle("bp_rel");
    chk("bp_next2", out_data, 64'd24556);

    // Wrap and skip: grant 5 sets ptr=6, then lanes 6 and 1
    in_valid = 8'b0010_0000;
    cycle("wrap_pre");
    in_valid = 8'b0100_0010;
    cycle("wrap");
    chk("wrap_sel6", 64'(out_sel), 64'd6);
    cycle("wrap");
    chk("wrap_sel1", 64'(out_sel), 64'd1);

    // Drain to empty: single lane-3 beat
    in_valid = 8'b0000_1000;
    cycle("drain");
    chk("drain_data", out_data, 64'd12328);
    chk("drain_valid", 64'(out_valid), 64'd1);
    in_valid = 8'h00;
    cycle("drain");
    chk("drain_empty", 64'(out_valid), 64'd0);
    cycle("drain");

    // Lock scenario on lanes 0 and 4 (ptr=4 here)
    in_valid = 8'b0001_0001;
    n4 = 0;
    for (int i = 0; i < 8; i++) begin
      in_lock = (n4 < 3) ? 8'h10 : 8'h00;
      cycle("lock");
`ifdef ARB_LOCK_EN
      e = (i < 4) ? 4 : (((i - 4) % 2 == 0) ? 0 : 4);
`else
      e = (i % 2 == 0) ? 4 : 0;
`endif
      chk("lock_sel", 64'(out_sel), 64'(e));
      if (m_sel == 4) n4++;
    end
    in_lock = 8'h00;

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      in_valid  = 8'($urandom);
      in_lock   = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 8; i++) in_data[i] = {$urandom, $urandom};
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter that shares one 64-bit 8:1 read-select path among eight requesting lanes. Each cycle it picks one valid lane, steers that lane's data through the 8:1 select and captures the result in a single output register with a valid/ready handshake. It sits between the register-file read lanes and a single downstream consumer. It drives the 3-bit select, so the mux select never comes from more than one owner.

## Interface
- WIDTH, 64, data width per lane
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  8  per-lane request; bit k means lane k holds data
- in_data  input  8x64  packed lane data, [7:0][63:0]
- in_lock  input  8  per-lane burst lock; used only with ARB_LOCK_EN
- in_ready  output  8  one-hot (or zero) grant; lane k's beat is consumed when in_valid[k] & in_ready[k]
- out_valid  output  1  output register holds a beat
- out_data  output  64  registered selected data
- out_sel  output  3  lane index of the beat in out_data
- out_ready  input  1  consumer accepts the beat when out_valid & out_ready

## Operation
- Output register has two states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- The block can load a new beat (`load_ok`) when the output register is EMPTY, or when it is FULL and out_ready=1. A FULL register with out_ready=1 drains and refills in the same cycle.
- Arbitration is combinational each cycle. It scans lanes ptr, ptr+1, …, ptr+7 (mod 8) and picks the first lane k with in_valid[k]=1.
- in_ready = onehot(k) when load_ok and at least one lane is valid; otherwise in_ready = 0.
- On a grant, the following load at the clock edge:
  - out_data ← in_data[k], using the mux select = k.
  - out_sel ← k.
  - out_valid ← 1.
  - ptr ← (k+1) mod 8. The 3-bit wrap is natural: 7+1 → 0.
- If the register drains (out_valid & out_ready) and no lane is valid, the next state is EMPTY (out_valid ← 0). out_data and out_sel hold their last values.
- If FULL and out_ready=0:
  - in_ready = 0.
  - out_data, out_sel and ptr hold.
  - Lanes must hold in_valid/in_data; no beat is dropped or duplicated.
- ptr changes only on a grant.
- in_valid may deassert without a grant (no stickiness required of lanes).
- Reset (async, any time, including mid-stall) forces:
  - out_valid=0, out_data=0, out_sel=0, ptr=0, lock_hold=0.
  - in_ready=0 while reset is high.
  - A beat held in the output register at reset is discarded.

## Timing
- Latency: lane beat accepted at edge N → visible on out_data/out_valid after edge N.
- Throughput: one beat per cycle while out_ready=1 and any lane is valid.
- Fairness: with all 8 lanes continuously valid, grants cycle 0,1,…,7,0. Each lane waits at most 7 grants.
- in_ready depends combinationally on in_valid, ptr, out_valid and out_ready. No combinational path exists from in_data to any output except through the register.
- Outputs out_valid, out_data and out_sel come directly from flops.

## Configuration
- ARB_LOCK_EN defined:
  - If lane k is granted with in_lock[k]=1, lock_hold is set to k.
  - While lock_hold is active, the arbiter grants only lane k. Other lanes get in_ready=0 even when k is idle.
  - The lock releases on the first granted beat of lane k with in_lock[k]=0. ptr then ← k+1.
  - ptr does not advance during a locked burst.
  - If in_valid[k] drops while locked, the block stalls waiting for lane k.
- ARB_LOCK_EN undefined:
  - in_lock is ignored and lock_hold logic is absent.
  - Pure round-robin as above.

## Test plan
- Reset then idle: assert reset mid-cycle with out_valid=1 → out_valid, out_data, out_sel and in_ready immediately 0. ptr=0 after release.
- Full contention: in_data = {7, 132346, 31, 63, 12328, 24556, 26000, 64357} for lanes 7..0, all valid, out_ready=1 → out_sel sequence 0..7 then 0. out_data 64357, 26000, …, 7. One beat per cycle.
- Backpressure: lanes 2 and 5 valid, out_ready=0 for 3 cycles after first load → out_data=24556 holds and in_ready=0. On release, lane 5 (value 31) is next, then 2.
- Wrap and skip: ptr=6 (after a grant to lane 5), only lanes 1 and 6 valid → grants 6 then 1. ptr wraps 7→0 correctly.
- Drain to empty: single beat from lane 3 (12328), out_ready=1, no further valid → out_valid high exactly one cycle, then 0.
- ARB_LOCK_EN: lanes 0 and 4 valid, lane 4 granted with in_lock[4]=1 for 3 beats then 0 → four consecutive lane-4 grants, lane 0 blocked. Then lane 0 is granted and ptr=5 after the lane-4 release. Without the macro, the same stimulus alternates 0/4.
